// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rxd, finds the start edge, samples each bit mid-period
// and presents good bytes with a one-cycle valid pulse; bad stop bits pulse frame_err.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronised line
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling the 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; after a framing error, waiting for the line to go high

module uart_rx #(
   parameter int SYSTEM_CLOCK = 32000000,
   parameter int BAUD_RATE    = 9600,
   parameter int CYC_COUNT    = SYSTEM_CLOCK / BAUD_RATE,
   parameter int HALF_COUNT   = CYC_COUNT / 2,
   parameter int CNT_W        = $clog2(CYC_COUNT) + 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
   output logic [1:0] state_out_dbg
);

   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYC_COUNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   state_t           state;
   logic             rxd_m;
   logic             rxd_s;
   logic             rxd_q;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             err_wait;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_q <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
         rxd_q <= rxd_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         data_out  <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         err_wait  <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rxd_q && !rxd_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rxd_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CYC_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rxd_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               // The cycle after the sample is spent here so busy drops after valid.
               if (valid) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (err_wait) begin
                  if (rxd_s) begin
                     state    <= IDLE;
                     err_wait <= 1'b0;
                     cnt      <= '0;
                  end
               end else if (cnt == CYC_LAST) begin
                  if (rxd_s) begin
                     data_out <= shreg;
                     valid    <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_wait  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy          = (state != IDLE);
   assign state_out_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: frames are driven from a task, expected bytes
// are queued at send time and compared when valid pulses.

module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       busy;
   logic [1:0] state_out_dbg;

   int n_chk  = 0;
   int n_err  = 0;
   int n_vld  = 0;
   int n_ferr = 0;
   logic [7:0] exp_q[$];
   logic prev_valid = 1'b0;

   uart_rx #(.SYSTEM_CLOCK(160), .BAUD_RATE(10)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rxd           (rxd),
      .data_out      (data_out),
      .valid         (valid),
      .frame_err     (frame_err),
      .busy          (busy),
      .state_out_dbg (state_out_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (valid) begin
         n_vld++;
         chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0)
            chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
         chk("busy_at_valid", 32'(busy), 32'd1);
      end
      if (frame_err)
         n_ferr++;
      if (valid || frame_err)
         chk("valid_ferr_excl", 32'(valid & frame_err), 32'd0);
      if (prev_valid)
         chk("busy_after_valid", 32'(busy), 32'd0);
      prev_valid = valid;
   end

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Frame of start + 8 data + stop; fast mode alternates 16/15-cycle bits (~3% short on average).
   task automatic send(input logic [7:0] b, input logic stop_bit, input bit fast);
      logic [9:0] frame;
      int p;
      frame = {stop_bit, b, 1'b0};
      if (stop_bit)
         exp_q.push_back(b);
      for (int i = 0; i < 10; i++) begin
         p = (fast && (i % 2 == 1)) ? 15 : 16;
         rxd = frame[i];
         repeat (p) @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int max, input string tag);
      int n = 0;
      while (state_out_dbg != 2'b00 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(state_out_dbg), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int f0;
      logic [7:0] b77;
      rst_n = 1'b0;
      rxd   = 1'b1;

      // reset held with line toggling
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rxd = ~rxd;
         chk("reset_outputs", {19'd0, data_out, valid, frame_err, busy, state_out_dbg}, 32'd0);
      end
      rxd   = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);

      // single good frame
      send(8'hA5, 1'b1, 1'b0);
      idle(4);
      chk("a5_valid_count", 32'(n_vld), 32'd1);
      chk("a5_no_ferr", 32'(n_ferr), 32'd0);
      chk("a5_data_hold", 32'(data_out), 32'hA5);
      idle(10);

      // short low glitch
      v0 = n_vld;
      f0 = n_ferr;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      wait_idle(12, "glitch_idle");
      idle(10);
      chk("glitch_no_valid", 32'(n_vld), 32'(v0));
      chk("glitch_no_ferr", 32'(n_ferr), 32'(f0));

      // bad stop bit, line held low
      v0 = n_vld;
      send(8'h3C, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      chk("ferr_count", 32'(n_ferr), 32'd1);
      chk("ferr_no_valid", 32'(n_vld), 32'(v0));
      chk("ferr_data_kept", 32'(data_out), 32'hA5);
      chk("ferr_hold_stop", 32'(state_out_dbg), 32'd3);
      rxd = 1'b1;
      wait_idle(6, "ferr_release_idle");
      idle(20);
      send(8'h5A, 1'b1, 1'b0);
      idle(20);
      chk("after_ferr_valid", 32'(n_vld), 32'(v0 + 1));

      // back-to-back frames, then a fast one
      send(8'h00, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b0);
      send(8'h81, 1'b1, 1'b1);
      idle(30);
      chk("b2b_valid_count", 32'(n_vld), 32'(v0 + 4));
      chk("b2b_last_data", 32'(data_out), 32'h81);

      // reset during data bit 4 of 0x77, sender aborts
      v0 = n_vld;
      b77 = 8'h77;
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = b77[i];
         repeat (16) @(negedge clk);
      end
      rxd = b77[4];
      repeat (6) @(negedge clk);
      chk("mid_frame_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_reset_state", 32'(state_out_dbg), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(40);
      chk("reset_no_valid", 32'(n_vld), 32'(v0));
      chk("reset_cleared_data", 32'(data_out), 32'h00);
      send(8'h55, 1'b1, 1'b0);
      idle(20);
      chk("post_reset_valid", 32'(n_vld), 32'(v0 + 1));

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("total_valid", 32'(n_vld), 32'd6);
      chk("total_ferr", 32'(n_ferr), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
